// File: rtl/interrupt_ack_sequencer.sv
// INTA sequencer for an 8259A-style PIC: synchronizes INTA_N, walks the two-pulse
// 8086 acknowledge, drives/compares cascade IDs and issues ISR-set / AEOI pulses.
module interrupt_ack_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       INTA_N,
   input  logic       int_pending,
   input  logic [2:0] highest_level,
   input  logic       SNGL,
   input  logic       SP,
   input  logic [7:0] icw3,
   input  logic [4:0] icw2_t,
   input  logic       aeoi,
   input  logic [2:0] CAS_in,
   output logic [2:0] CAS_out,
   output logic       CAS_oe,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       freeze,
   output logic       isr_set,
   output logic [2:0] isr_level,
   output logic       eoi_auto,
   output logic       ack_active
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACK1  = 2'd1;
   localparam logic [1:0] WAIT2 = 2'd2;
   localparam logic [1:0] ACK2  = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   fall_q;
   logic                   rise_q;

   logic [1:0] state_q, state_d;
   logic [2:0] level_q;
   logic       owns_q;
   logic       issued_q;
   logic       setPend_q;
   logic       isrSet_q;
   logic [2:0] casOut_q;
   logic       casOe_q;
   logic [7:0] dataOut_q;
   logic       dataOe_q;
   logic       ackActive_q;
   logic       eoi_q;

   logic [2:0] level_d;
   logic       isMaster;
   logic       isSlave;
   logic       cascade_d;
   logic       owns_d;
   logic       issue_d;
   logic       enterAck1;
   logic       enterAck2;
   logic       exitAck2;

   // Edge flags are registered, so a strobe edge moves the FSM SYNC_STAGES+2 clocks later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
         fall_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], INTA_N};
         prev_q <= sync_q[SYNC_STAGES-1];
         fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
         rise_q <= ~prev_q & sync_q[SYNC_STAGES-1];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fall_q) state_d = ACK1;
         ACK1:    if (rise_q) state_d = WAIT2;
         WAIT2:   if (fall_q) state_d = ACK2;
         ACK2:    if (rise_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Role and vector ownership are decided once, from the inputs seen at ACK1 entry.
   assign level_d   = int_pending ? highest_level : 3'd7;
   assign isMaster  = ~SNGL & SP;
   assign isSlave   = ~SNGL & ~SP;
   assign cascade_d = isMaster & icw3[level_d];
   assign owns_d    = SNGL | (isMaster & ~icw3[level_d]) | (isSlave & (CAS_in == icw3[2:0]));
   assign issue_d   = int_pending & (owns_d | cascade_d);

   assign enterAck1 = (state_q == IDLE)  & fall_q;
   assign enterAck2 = (state_q == WAIT2) & fall_q;
   assign exitAck2  = (state_q == ACK2)  & rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         level_q     <= 3'd0;
         owns_q      <= 1'b0;
         issued_q    <= 1'b0;
         setPend_q   <= 1'b0;
         isrSet_q    <= 1'b0;
         casOut_q    <= 3'd0;
         casOe_q     <= 1'b0;
         dataOut_q   <= 8'd0;
         dataOe_q    <= 1'b0;
         ackActive_q <= 1'b0;
         eoi_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         isrSet_q  <= setPend_q;
         setPend_q <= 1'b0;
         eoi_q     <= 1'b0;
         if (enterAck1) begin
            level_q     <= level_d;
            owns_q      <= owns_d;
            issued_q    <= issue_d;
            setPend_q   <= issue_d;
            ackActive_q <= 1'b1;
            if (cascade_d) begin
               casOut_q <= level_d;
               casOe_q  <= 1'b1;
            end
         end
         if (enterAck2 && owns_q) begin
            dataOe_q  <= 1'b1;
            dataOut_q <= {icw2_t, level_q};
         end
         if (exitAck2) begin
            dataOe_q    <= 1'b0;
            casOe_q     <= 1'b0;
            ackActive_q <= 1'b0;
            eoi_q       <= aeoi & issued_q;
         end
      end
   end

   assign CAS_out    = casOut_q;
   assign CAS_oe     = casOe_q;
   assign data_out   = dataOut_q;
   assign data_oe    = dataOe_q;
   assign freeze     = ackActive_q;
   assign ack_active = ackActive_q;
   assign isr_set    = isrSet_q;
   assign isr_level  = level_q;
   assign eoi_auto   = eoi_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for interrupt_ack_sequencer: directed INTA_N pulse pairs push expected
// output events; a negedge monitor pops and compares them as the DUT produces them.
module tb_interrupt_ack_sequencer;

   localparam int K_CAS  = 0;
   localparam int K_ISR  = 1;
   localparam int K_DATA = 2;
   localparam int K_DLEN = 3;
   localparam int K_CLEN = 4;
   localparam int K_EOI  = 5;
   localparam int K_ACT  = 6;

   localparam int LOWC = 3;
   localparam int GAPC = 5;
   localparam int ACTLEN = 2 * LOWC + GAPC;

   typedef struct {
      int kind;
      int value;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       INTA_N;
   logic       int_pending;
   logic [2:0] highest_level;
   logic       SNGL;
   logic       SP;
   logic [7:0] icw3;
   logic [4:0] icw2_t;
   logic       aeoi;
   logic [2:0] CAS_in;
   logic [2:0] CAS_out;
   logic       CAS_oe;
   logic [7:0] data_out;
   logic       data_oe;
   logic       freeze;
   logic       isr_set;
   logic [2:0] isr_level;
   logic       eoi_auto;
   logic       ack_active;

   ev_t sb[$];
   int  assertions = 0;
   int  failures = 0;

   interrupt_ack_sequencer #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .INTA_N(INTA_N), .int_pending(int_pending),
      .highest_level(highest_level), .SNGL(SNGL), .SP(SP), .icw3(icw3),
      .icw2_t(icw2_t), .aeoi(aeoi), .CAS_in(CAS_in), .CAS_out(CAS_out),
      .CAS_oe(CAS_oe), .data_out(data_out), .data_oe(data_oe), .freeze(freeze),
      .isr_set(isr_set), .isr_level(isr_level), .eoi_auto(eoi_auto),
      .ack_active(ack_active)
   );

   always #5 clk = ~clk;

   function automatic string kindName(input int kind);
      case (kind)
         K_CAS:   return "cas_drive";
         K_ISR:   return "isr_set";
         K_DATA:  return "vector";
         K_DLEN:  return "data_oe_len";
         K_CLEN:  return "cas_oe_len";
         K_EOI:   return "eoi_auto";
         K_ACT:   return "ack_active_len";
         default: return "unknown";
      endcase
   endfunction

   task automatic pushExp(input int kind, input int value);
      ev_t e;
      e.kind  = kind;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input int kind, input int actual);
      ev_t e;
      assertions++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL unexpected %s: got %0d, nothing expected", kindName(kind), actual);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.value != actual) begin
            failures++;
            $display("[TB] FAIL %s: got %s=%0d, expected %s=%0d", kindName(kind),
                     kindName(kind), actual, kindName(e.kind), e.value);
         end
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Two INTA_N pulses, then idle long enough for every delayed response to drain.
   task automatic applyStimulus(input string name);
      INTA_N = 1'b0; tick(LOWC);
      INTA_N = 1'b1; tick(GAPC);
      INTA_N = 1'b0; tick(LOWC);
      INTA_N = 1'b1; tick(10);
      checkValue({name, "_pending_events"}, sb.size(), 0);
      sb.delete();
   endtask

   // isr_set is tagged with the ack_active cycle count (expected 2), eoi_auto with whether
   // ack_active fell in the same cycle (+8), so timing errors change the compared value.
   int  actLen, dataLen, casLen;
   logic ackPrev, dataPrev, casPrev;
   always @(negedge clk) begin
      if (!rst_n) begin
         actLen = 0; dataLen = 0; casLen = 0;
         ackPrev = 1'b0; dataPrev = 1'b0; casPrev = 1'b0;
      end else begin
         if (ack_active) actLen++;
         if (data_oe) dataLen++;
         if (CAS_oe) casLen++;
         if (CAS_oe && !casPrev) checkOutput(K_CAS, int'(CAS_out));
         if (isr_set) checkOutput(K_ISR, int'(isr_level) + 8 * actLen);
         if (data_oe && !dataPrev) checkOutput(K_DATA, int'(data_out));
         if (!data_oe && dataPrev) begin
            checkOutput(K_DLEN, dataLen);
            dataLen = 0;
         end
         if (!CAS_oe && casPrev) begin
            checkOutput(K_CLEN, casLen);
            casLen = 0;
         end
         if (eoi_auto) checkOutput(K_EOI, int'(isr_level) + ((ackPrev && !ack_active) ? 8 : 0));
         if (!ack_active && ackPrev) begin
            checkOutput(K_ACT, actLen);
            actLen = 0;
         end
         ackPrev  = ack_active;
         dataPrev = data_oe;
         casPrev  = CAS_oe;
      end
   end

   initial begin
      rst_n = 1'b0; INTA_N = 1'b1; int_pending = 1'b0; highest_level = 3'd0;
      SNGL = 1'b1; SP = 1'b0; icw3 = 8'h00; icw2_t = 5'b01000; aeoi = 1'b0; CAS_in = 3'd0;
      tick(3);
      checkValue("reset_outputs",
                 int'({CAS_out, CAS_oe, data_out, data_oe, freeze, isr_set, isr_level,
                       eoi_auto, ack_active}), 0);
      rst_n = 1'b1;
      tick(2);

      $display("[TB] single mode, level 3");
      int_pending = 1'b1; highest_level = 3'd3;
      pushExp(K_ISR, 3 + 16); pushExp(K_DATA, 8'h43); pushExp(K_DLEN, LOWC); pushExp(K_ACT, ACTLEN);
      applyStimulus("single");

      $display("[TB] master, cascaded level 2");
      SNGL = 1'b0; SP = 1'b1; icw3 = 8'h04; highest_level = 3'd2;
      pushExp(K_CAS, 2); pushExp(K_ISR, 2 + 16); pushExp(K_CLEN, ACTLEN); pushExp(K_ACT, ACTLEN);
      applyStimulus("master_cascade");

      $display("[TB] master, own level 5");
      highest_level = 3'd5;
      pushExp(K_ISR, 5 + 16); pushExp(K_DATA, 8'h45); pushExp(K_DLEN, LOWC); pushExp(K_ACT, ACTLEN);
      applyStimulus("master_own");

      $display("[TB] slave selected");
      SP = 1'b0; icw3 = 8'h05; icw2_t = 5'b10010; CAS_in = 3'd5; highest_level = 3'd4;
      pushExp(K_ISR, 4 + 16); pushExp(K_DATA, 8'h94); pushExp(K_DLEN, LOWC); pushExp(K_ACT, ACTLEN);
      applyStimulus("slave_sel");

      $display("[TB] slave not selected");
      CAS_in = 3'd4; aeoi = 1'b1;
      pushExp(K_ACT, ACTLEN);
      applyStimulus("slave_unsel");

      $display("[TB] spurious");
      SNGL = 1'b1; int_pending = 1'b0; icw2_t = 5'b00001; highest_level = 3'd2;
      pushExp(K_DATA, 8'h0F); pushExp(K_DLEN, LOWC); pushExp(K_ACT, ACTLEN);
      applyStimulus("spurious");

      $display("[TB] aeoi, level 6");
      int_pending = 1'b1; highest_level = 3'd6; icw2_t = 5'b01000;
      pushExp(K_ISR, 6 + 16); pushExp(K_DATA, 8'h46); pushExp(K_DLEN, LOWC);
      pushExp(K_EOI, 6 + 8); pushExp(K_ACT, ACTLEN);
      applyStimulus("aeoi");

      $display("[TB] reset in WAIT2");
      highest_level = 3'd1;
      pushExp(K_ISR, 1 + 16);
      INTA_N = 1'b0; tick(LOWC);
      INTA_N = 1'b1; tick(6);
      checkValue("wait2_ack_active", int'(ack_active), 1);
      #3 rst_n = 1'b0;
      #1;
      checkValue("midcycle_reset_outputs",
                 int'({CAS_out, CAS_oe, data_out, data_oe, freeze, isr_set, isr_level,
                       eoi_auto, ack_active}), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      checkValue("reset_pending_events", sb.size(), 0);
      sb.delete();
      pushExp(K_ISR, 1 + 16); pushExp(K_DATA, 8'h41); pushExp(K_DLEN, LOWC);
      pushExp(K_EOI, 1 + 8); pushExp(K_ACT, ACTLEN);
      applyStimulus("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Clocked INTA sequencer for the 8259A-style PIC, sitting between the priority resolver and the cascade/data-bus buffers. It synchronizes the asynchronous INTA_N strobe and walks the 8086-mode two-pulse acknowledge cycle. In master mode it drives the cascade ID onto CAS. In slave mode it compares CAS against its ICW3 ID. It enables the vector byte only when this device owns the vector, and it issues the ISR-set and automatic-EOI pulses.

## Interface
- SYNC_STAGES, 2, flops in the INTA_N synchronizer (minimum 2).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- INTA_N  in  1  raw CPU acknowledge strobe, asynchronous, active low.
- int_pending  in  1  priority resolver has an unmasked request above the in-service level.
- highest_level  in  3  level chosen by the priority resolver.
- SNGL  in  1  ICW1 single mode (1 = no cascade).
- SP  in  1  master/slave select (1 = master), used only when SNGL=0.
- icw3  in  8  master: bit n = slave on IR n; slave: [2:0] = own ID.
- icw2_t  in  5  vector bits T7..T3.
- aeoi  in  1  ICW4 automatic EOI.
- CAS_in  in  3  cascade lines as sampled from the pad.
- CAS_out  out  3  cascade ID driven by the master.
- CAS_oe  out  1  CAS output enable.
- data_out  out  8  vector byte.
- data_oe  out  1  data bus output enable.
- freeze  out  1  holds IRR/priority inputs stable during acknowledge.
- isr_set  out  1  one-cycle pulse: set ISR bit isr_level.
- isr_level  out  3  level latched at the first pulse.
- eoi_auto  out  1  one-cycle pulse: clear ISR bit isr_level (AEOI).
- ack_active  out  1  high from first INTA_N fall until second rise.

## Operation
- INTA_N passes through SYNC_STAGES flops plus one history flop.
  - fall = prev & ~cur.
  - rise = ~prev & cur.
- States and transitions:
  - IDLE -> ACK1 on fall.
  - ACK1 -> WAIT2 on rise.
  - WAIT2 -> ACK2 on fall.
  - ACK2 -> IDLE on rise.
  - All other edges leave the state unchanged.
- On IDLE->ACK1:
  - Latch isr_level = int_pending ? highest_level : 3'd7 (spurious IR7).
  - Set freeze=1 and ack_active=1.
- Role classification, made once at ACK1 entry:
  - single: SNGL=1.
  - master: SNGL=0, SP=1.
  - slave: SNGL=0, SP=0.
- Master with icw3[isr_level]=1 (cascaded level):
  - CAS_out = isr_level and CAS_oe = 1 from ACK1 entry until ACK2 exit.
  - data_oe stays 0 for the whole cycle (the slave supplies the vector).
- Master with a non-cascaded level, and single: CAS_oe stays 0; the device owns the vector.
- Slave:
  - At ACK1 entry, selected = (CAS_in == icw3[2:0]).
  - If not selected: no isr_set, no data_oe, no eoi_auto; state still tracks INTA_N.
- isr_set pulses for one cycle on the cycle after ACK1 entry:
  - when the device owns the vector or is a cascading master;
  - not when int_pending=0 (spurious).
- In ACK2, if the device owns the vector:
  - data_oe = 1.
  - data_out = {icw2_t, isr_level}; for spurious, data_out uses level 7.
- On ACK2->IDLE:
  - data_oe, CAS_oe, freeze and ack_active drop.
  - eoi_auto pulses for one cycle if aeoi=1 and isr_set was issued.
- Reset, including mid-cycle, forces IDLE and clears the synchronizer.
  - Synchronizer flops reset to 1 (INTA_N inactive).
  - A sequence interrupted by reset is abandoned: no eoi_auto.

## Timing
- Reset values:
  - CAS_out=0, CAS_oe=0, data_out=0, data_oe=0.
  - freeze=0, isr_set=0, isr_level=0, eoi_auto=0, ack_active=0.
- All outputs are registered.
- An INTA_N edge is detected SYNC_STAGES+1 rising clk edges after it occurs. The state and its outputs change at the next edge: 4 cycles with the default.
- isr_set asserts one cycle after ack_active rises.
- data_oe tracks ACK2 exactly, so it asserts and releases with the same 4-cycle lag as the INTA_N edges.
- INTA_N pulses shorter than SYNC_STAGES+1 cycles are not guaranteed to be detected.
- highest_level and int_pending are sampled only at ACK1 entry; later changes are ignored.

## Test plan
- Single mode, icw2_t=5'b01000, highest_level=3, int_pending=1, two INTA_N pulses:
  - isr_set pulses with isr_level=3.
  - data_oe only in ACK2, data_out=8'h43.
  - CAS_oe stays 0.
- Master, icw3=8'h04, highest_level=2:
  - CAS_out=2 and CAS_oe=1 across both pulses.
  - data_oe never asserts; isr_set pulses.
- Slave, icw3=8'h05, icw2_t=5'b10010:
  - CAS_in=5: data_out=8'h9x in ACK2 with x = level.
  - CAS_in=4: no isr_set and no data_oe.
- Spurious: int_pending=0, icw2_t=5'b00001:
  - data_out=8'h0F.
  - no isr_set, no eoi_auto.
- aeoi=1, single mode, level 6: eoi_auto pulses once, with isr_level=6, 4 cycles after the second INTA_N rise.
- rst_n asserted in WAIT2:
  - All outputs return to reset values immediately.
  - A following pulse pair runs a clean new cycle.
